// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_hazard_ctrl                                           |
// | Description : Stall/flush sequencer for a 5-stage MIPS front end.        |
// |               Combinational priority arbitration of dmem busy, load-use |
// |               hazard, ID redirect and imem not-ready; a small FSM kills |
// |               FLUSH_CYCLES wrong-path fetches after each redirect.      |
// |               Optional perf counters: define HAZARD_PERF_CNT_EN.        |
// | Revision    : 1.0  initial release                                      |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_ex_mem_read,
  input  logic [4:0]       i_ex_rt,
  input  logic             i_redirect,
  input  logic             i_imem_ready,
  input  logic             i_dmem_busy,
  output logic             o_pc_we,
  output logic             o_if_id_we,
  output logic             o_if_id_flush,
  output logic             o_id_ex_we,
  output logic             o_id_ex_bubble,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam logic [2:0] C_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t     r_state;
  logic [2:0] r_fcnt;

  logic w_hz;
  logic w_in_flush;
  logic w_redirect_acc;
  logic w_flush_dec;

  // Hazard detection and event qualification (priority order applied here).
  always_comb begin
    w_hz = i_ex_mem_read && (i_ex_rt != 5'd0) &&
           ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
    w_in_flush     = (r_state == ST_FLUSH);
    w_redirect_acc = rst_n && !i_dmem_busy && !w_hz && i_redirect;
    // A wrong-path fetch is killed only when it actually arrives and nothing
    // of higher priority is holding the front end.
    w_flush_dec    = rst_n && w_in_flush && !i_dmem_busy && !w_hz &&
                     !i_redirect && i_imem_ready;
  end

  // Same-cycle enable/flush/bubble decision; reset forces a safe NOP pattern.
  always_comb begin
    o_pc_we        = 1'b1;
    o_if_id_we     = 1'b1;
    o_if_id_flush  = w_in_flush;
    o_id_ex_we     = 1'b1;
    o_id_ex_bubble = 1'b0;
    if (!rst_n) begin
      o_pc_we        = 1'b0;
      o_if_id_we     = 1'b0;
      o_if_id_flush  = 1'b1;
      o_id_ex_we     = 1'b1;
      o_id_ex_bubble = 1'b1;
    end else if (i_dmem_busy) begin
      o_pc_we        = 1'b0;
      o_if_id_we     = 1'b0;
      o_if_id_flush  = 1'b0;
      o_id_ex_we     = 1'b0;
    end else if (w_hz) begin
      o_pc_we        = 1'b0;
      o_if_id_we     = 1'b0;
      o_id_ex_bubble = 1'b1;
    end else if (i_redirect) begin
      o_if_id_flush  = 1'b1;
    end else if (!i_imem_ready) begin
      o_pc_we        = 1'b0;
      o_if_id_flush  = 1'b1;
    end
  end

  // Flush sequencer: redirect (re)loads the kill count, arriving fetches drain it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_fcnt  <= 3'd0;
    end else if (w_redirect_acc) begin
      if (FLUSH_CYCLES > 1) begin
        r_state <= ST_FLUSH;
        r_fcnt  <= C_FLUSH_RELOAD;
      end
    end else if (w_flush_dec) begin
      r_fcnt <= r_fcnt - 3'd1;
      if (r_fcnt == 3'd1) begin
        r_state <= ST_RUN;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!o_pc_we && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
      end
      if (w_redirect_acc && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + C_CNT_ONE;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS front end.
- Drives the PC write-enable, the IF/ID register's write-enable and flush, and the ID/EX bubble/enable.
- Arbitrates four causes of pipeline disturbance: data-memory busy, load-use hazard, ID-resolved control redirect, instruction-memory not ready.
- Decisions are combinational, same cycle. A small FSM sequences multi-cycle wrong-path flushes. Optional performance counters.

Parameters:
- FLUSH_CYCLES, 1: wrong-path fetches killed after a redirect (1..7).
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination register of the load in EX
- redirect  in  1  ID resolved a taken branch or jump
- imem_ready  in  1  instruction memory returns valid data this cycle
- dmem_busy  in  1  data memory not done; whole pipe must freeze
- pc_we  out  1  PC register load enable
- if_id_we  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID loads NOP (0x00000000) instead of fetched word
- id_ex_we  out  1  ID/EX register load enable
- id_ex_bubble  out  1  ID/EX loads all-zero control (NOP)
- stall_cnt  out  CNT_W  cycles with pc_we=0 (see Optional Feature)
- flush_cnt  out  CNT_W  redirect events accepted

Behaviour:
- Reset (rst_n=0, async): state=RUN, flush counter=0, perf counters=0.
- While in reset, outputs are forced: pc_we=0, if_id_we=0, if_id_flush=1, id_ex_we=1, id_ex_bubble=1.
- Load-use hazard: hz = ex_mem_read & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- Priority, highest first:
  - 1) dmem_busy: pc_we=0, if_id_we=0, id_ex_we=0, no flush/bubble. The FSM holds state and the flush counter; redirect and hz are ignored.
  - 2) hz: pc_we=0, if_id_we=0, id_ex_bubble=1, id_ex_we=1. Redirect is ignored, since the branch operands are invalid.
  - 3) redirect: pc_we=1, if_id_we=1, if_id_flush=1.
    - If FLUSH_CYCLES>1: go to FLUSH with the counter at FLUSH_CYCLES-1.
    - flush_cnt increments.
  - 4) imem_ready=0: pc_we=0, if_id_we=1, if_id_flush=1, so a NOP enters ID and downstream continues.
  - 5) none: pc_we=1, if_id_we=1, all flush/bubble=0, id_ex_we=1.
- FSM states:
  - RUN: normal operation as above.
  - FLUSH: if_id_flush=1 every cycle. pc_we follows imem_ready.
    - The counter decrements only on cycles with imem_ready=1 and no dmem_busy.
    - Return to RUN when the counter reaches 0 on a decrement.
    - A new redirect in FLUSH (only possible at priority 3, since ID holds NOPs) reloads the counter and increments flush_cnt.
- Same-cycle behaviour: hz and redirect together gives the stall only; redirect is re-evaluated next cycle because ID is held.
- Reset mid-FLUSH aborts the sequence and returns to RUN.
- No output is registered; latency is 0 cycles from input to enable.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each non-reset cycle with pc_we=0.
  - flush_cnt increments per accepted redirect.
  - Both saturate at 2^CNT_W-1 and are cleared only by reset.
- Undefined: both counters are removed and stall_cnt and flush_cnt are tied to 0.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5, for one cycle, then ex_mem_read=0 → that cycle pc_we=0, if_id_we=0, id_ex_bubble=1; the next cycle is all normal. stall_cnt=1.
- Zero register: ex_mem_read=1, ex_rt=0, id_rs=0 → no stall, pc_we=1.
- id_uses_rt=0: ex_rt=7, id_rt=7, id_rs=3 → no stall. With id_uses_rt=1 → stall.
- Multi-cycle flush, FLUSH_CYCLES=3: redirect pulse, then imem_ready=0 for 1 cycle mid-flush → if_id_flush=1 for 4 consecutive cycles (the redirect cycle, 1 decrement, 1 non-decrement imem stall, 1 decrement), then RUN. flush_cnt=1.
- dmem_busy=1 for 3 cycles while redirect=1 is held → pc_we=0, if_id_we=0, id_ex_we=0 for 3 cycles; the redirect is honoured on cycle 4.
- With HAZARD_PERF_CNT_EN, CNT_W=4, 20 consecutive hz cycles → stall_cnt saturates at 15. Assert rst_n=0 during a FLUSH → state RUN and counters 0 immediately.
